// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU register/data types and forwarding select-width helper
package cpu_types_pkg;

    localparam int REG_BITS  = 5;
    localparam int WORD_BITS = 32;

    typedef logic [REG_BITS-1:0]  regbits_t;
    typedef logic [WORD_BITS-1:0] word_t;

    // Select encodes RF (0), each stage (1..nsrc) and the capture register (nsrc+1).
    function automatic int fwd_selw(input int nsrc);
        return $clog2(nsrc + 2);
    endfunction

endpackage

// File: rtl/fwd_operand_slice.sv
// rtl/fwd_operand_slice.sv - per-operand producer match, priority select, capture register and stall term
import cpu_types_pkg::*;

module fwd_operand_slice #(
    parameter int NSRC  = 3,
    parameter int REGW  = 5,
    parameter int DATAW = 32,
    parameter int SELW  = fwd_selw(NSRC)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [REGW-1:0]       rs,
    input  logic [DATAW-1:0]      rf_data,
    input  logic [NSRC-1:0]       src_regwrite,
    input  logic [NSRC*REGW-1:0]  src_rd,
    input  logic [NSRC*DATAW-1:0] src_wdata,
    input  logic [NSRC-1:0]       src_dvalid,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic [SELW-1:0]       sel,
    output logic [DATAW-1:0]      data,
    output logic                  stall
);

    logic              win_found;
    logic              win_dvalid;
    logic [SELW-1:0]   win_sel;
    logic [DATAW-1:0]  win_data;
    logic              cap_valid;
    logic [DATAW-1:0]  cap_data;

    // Find the youngest matching producer; scanning old-to-young lets the youngest overwrite.
    always_comb begin
        win_found  = 1'b0;
        win_dvalid = 1'b0;
        win_sel    = '0;
        win_data   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_regwrite[i] && (src_rd[i*REGW +: REGW] != '0) &&
                (src_rd[i*REGW +: REGW] == rs)) begin
                win_found  = 1'b1;
                win_dvalid = src_dvalid[i];
                win_sel    = SELW'(i + 1);
                win_data   = src_wdata[i*DATAW +: DATAW];
            end
        end
    end

    // Capture wins over live forwarding; an invalid youngest producer stalls rather than falling back.
    always_comb begin
        if (cap_valid) begin
            sel  = SELW'(NSRC + 1);
            data = cap_data;
        end else if (win_found) begin
            sel  = win_sel;
            data = win_data;
        end else begin
            sel  = '0;
            data = rf_data;
        end
        stall = !cap_valid && win_found && !win_dvalid;
    end

    // Hold the forwarded value while EX is frozen so it outlives the producer draining away.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else if (flush || !ex_stall) begin
            cap_valid <= 1'b0;
        end else if (!cap_valid && win_found && win_dvalid) begin
            cap_valid <= 1'b1;
            cap_data  <= win_data;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - EX operand forwarding and data-hazard unit; FWD_PERF_EN adds perf counters
import cpu_types_pkg::*;

module forwarding_hazard_unit #(
    parameter int NSRC  = 3,
    parameter int NOPS  = 2,
    parameter int REGW  = 5,
    parameter int DATAW = 32
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NOPS*REGW-1:0]                 ex_rs,
    input  logic [NOPS*DATAW-1:0]                ex_rf_data,
    input  logic [NSRC-1:0]                      src_regwrite,
    input  logic [NSRC*REGW-1:0]                 src_rd,
    input  logic [NSRC*DATAW-1:0]                src_wdata,
    input  logic [NSRC-1:0]                      src_dvalid,
    input  logic                                 ex_stall,
    input  logic                                 flush,
    output logic [NOPS*fwd_selw(NSRC)-1:0]       fwd_sel,
    output logic [NOPS*DATAW-1:0]                fwd_data,
    output logic                                 data_stall
`ifdef FWD_PERF_EN
    ,
    output logic [31:0]                          perf_stall_cnt,
    output logic [NSRC*32-1:0]                   perf_fwd_cnt
`endif
);

    localparam int SELW = fwd_selw(NSRC);

    logic [NOPS-1:0] op_stall;

    genvar k;
    generate
        for (k = 0; k < NOPS; k++) begin : g_op
            fwd_operand_slice #(
                .NSRC (NSRC),
                .REGW (REGW),
                .DATAW(DATAW),
                .SELW (SELW)
            ) u_slice (
                .CLK         (CLK),
                .nRST        (nRST),
                .rs          (ex_rs[k*REGW +: REGW]),
                .rf_data     (ex_rf_data[k*DATAW +: DATAW]),
                .src_regwrite(src_regwrite),
                .src_rd      (src_rd),
                .src_wdata   (src_wdata),
                .src_dvalid  (src_dvalid),
                .ex_stall    (ex_stall),
                .flush       (flush),
                .sel         (fwd_sel[k*SELW +: SELW]),
                .data        (fwd_data[k*DATAW +: DATAW]),
                .stall       (op_stall[k])
            );
        end
    endgenerate

    // Any operand waiting on an in-flight producer freezes EX.
    assign data_stall = |op_stall;

`ifdef FWD_PERF_EN
    logic [NSRC-1:0] stage_used;

    // A stage supplies an operand when some operand's select points directly at it.
    always_comb begin
        stage_used = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int o = 0; o < NOPS; o++) begin
                if (fwd_sel[o*SELW +: SELW] == SELW'(s + 1)) begin
                    stage_used[s] = 1'b1;
                end
            end
        end
    end

    // Stall-cycle counter; wraps naturally and ignores flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_stall_cnt <= '0;
        end else if (data_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

    genvar s;
    generate
        for (s = 0; s < NSRC; s++) begin : g_perf
            // Per-stage forwarding counter, only for cycles where EX actually advances.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    perf_fwd_cnt[s*32 +: 32] <= '0;
                end else if (stage_used[s] && !ex_stall) begin
                    perf_fwd_cnt[s*32 +: 32] <= perf_fwd_cnt[s*32 +: 32] + 32'd1;
                end
            end
        end
    endgenerate
`endif

endmodule
